// File: rtl/ysyx_24080014_mem_arbiter.sv
// Two-master (IFU, LSU) to one-slave memory arbiter with round-robin tie break
// and a bounded response wait that turns a hung memory into an error response.
module ysyx_24080014_mem_arbiter #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,

   input  logic                ifu_req_valid,
   output logic                ifu_req_ready,
   input  logic [ADDR_W-1:0]   ifu_addr,
   output logic                ifu_rsp_valid,
   input  logic                ifu_rsp_ready,
   output logic [DATA_W-1:0]   ifu_rdata,
   output logic                ifu_rsp_err,

   input  logic                lsu_req_valid,
   output logic                lsu_req_ready,
   input  logic [ADDR_W-1:0]   lsu_addr,
   input  logic                lsu_wen,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wmask,
   output logic                lsu_rsp_valid,
   input  logic                lsu_rsp_ready,
   output logic [DATA_W-1:0]   lsu_rdata,
   output logic                lsu_rsp_err,

   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_wen,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic                mem_rsp_valid,
   output logic                mem_rsp_ready,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_rsp_err
);

   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam logic [1:0] S_ERR  = 2'd3;

   localparam logic OWN_IFU = 1'b0;
   localparam logic OWN_LSU = 1'b1;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              wen;
      logic [DATA_W-1:0] wdata;
      logic [STRB_W-1:0] wmask;
   } req_t;

   logic [1:0]       state_q, state_d;
   logic             owner_q, owner_d;
   logic             last_grant_q, last_grant_d;
   req_t             req_q, req_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic grant_ifu;
   logic grant_lsu;
   logic owner_rsp_ready;

   // On a tie the master that was not served last wins.
   assign grant_ifu = (state_q == S_IDLE) && ifu_req_valid &&
                      (!lsu_req_valid || (last_grant_q == OWN_LSU));
   assign grant_lsu = (state_q == S_IDLE) && lsu_req_valid && !grant_ifu;

   assign owner_rsp_ready = (owner_q == OWN_LSU) ? lsu_rsp_ready : ifu_rsp_ready;

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         owner_q      <= OWN_IFU;
         last_grant_q <= OWN_IFU;
         req_q        <= '0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         req_q        <= req_d;
         cnt_q        <= cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      req_d        = req_q;
      cnt_d        = cnt_q;

      case (state_q)
         S_IDLE: begin
            if (grant_ifu) begin
               req_d.addr  = ifu_addr;
               req_d.wen   = 1'b0;
               req_d.wdata = '0;
               req_d.wmask = '0;
               owner_d     = OWN_IFU;
               state_d     = S_REQ;
            end else if (grant_lsu) begin
               req_d.addr  = lsu_addr;
               req_d.wen   = lsu_wen;
               req_d.wdata = lsu_wdata;
               req_d.wmask = lsu_wmask;
               owner_d     = OWN_LSU;
               state_d     = S_REQ;
            end
         end
         S_REQ: begin
            if (mem_req_ready) begin
               cnt_d   = '0;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            // The wait only counts cycles where memory has not answered at all.
            if (mem_rsp_valid) begin
               if (owner_rsp_ready) begin
                  last_grant_d = owner_q;
                  state_d      = S_IDLE;
               end
            end else if (cnt_q == CNT_W'(TIMEOUT)) begin
               state_d = S_ERR;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_ERR: begin
            if (owner_rsp_ready) begin
               last_grant_d = owner_q;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Handshake and data routing; everything is held at zero while in reset.
   always_comb begin
      ifu_req_ready = 1'b0;
      ifu_rsp_valid = 1'b0;
      ifu_rdata     = '0;
      ifu_rsp_err   = 1'b0;
      lsu_req_ready = 1'b0;
      lsu_rsp_valid = 1'b0;
      lsu_rdata     = '0;
      lsu_rsp_err   = 1'b0;
      mem_req_valid = 1'b0;
      mem_addr      = '0;
      mem_wen       = 1'b0;
      mem_wdata     = '0;
      mem_wmask     = '0;
      mem_rsp_ready = 1'b0;

      if (rst) begin
         case (state_q)
            S_IDLE: begin
               ifu_req_ready = grant_ifu;
               lsu_req_ready = grant_lsu;
               // Late responses after a timeout are drained here.
               mem_rsp_ready = 1'b1;
            end
            S_REQ: begin
               mem_req_valid = 1'b1;
               mem_addr      = req_q.addr;
               mem_wen       = req_q.wen;
               mem_wdata     = req_q.wdata;
               mem_wmask     = req_q.wmask;
            end
            S_RESP: begin
               mem_rsp_ready = owner_rsp_ready;
               if (owner_q == OWN_LSU) begin
                  lsu_rsp_valid = mem_rsp_valid;
                  lsu_rdata     = mem_rdata;
                  lsu_rsp_err   = mem_rsp_err;
               end else begin
                  ifu_rsp_valid = mem_rsp_valid;
                  ifu_rdata     = mem_rdata;
                  ifu_rsp_err   = mem_rsp_err;
               end
            end
            S_ERR: begin
               if (owner_q == OWN_LSU) begin
                  lsu_rsp_valid = 1'b1;
                  lsu_rsp_err   = 1'b1;
               end else begin
                  ifu_rsp_valid = 1'b1;
                  ifu_rsp_err   = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_24080014_mem_arbiter.sv
// Directed self-checking bench for ysyx_24080014_mem_arbiter (TIMEOUT = 4).
module tb_ysyx_24080014_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready, ifu_rsp_err;
   logic [31:0] ifu_addr, ifu_rdata;
   logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_ready, lsu_rsp_err;
   logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
   logic [3:0]  lsu_wmask;
   logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, mem_rsp_ready, mem_rsp_err;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wmask;

   int checks = 0;
   int errors = 0;

   ysyx_24080014_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rdata(ifu_rdata),
      .ifu_rsp_err(ifu_rsp_err),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
      .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rdata(lsu_rdata),
      .lsu_rsp_err(lsu_rsp_err),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rdata(mem_rdata),
      .mem_rsp_err(mem_rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

   // Advance to just after the next rising edge; inputs are driven from here.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs();
      ifu_req_valid = 0; ifu_addr = '0; ifu_rsp_ready = 1;
      lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
      lsu_rsp_ready = 1;
      mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = '0; mem_rsp_err = 0;
   endtask

   // Runs the REQ and RESP cycles of an already granted transaction.
   task automatic finish_txn(input logic [31:0] data);
      mem_req_ready = 1;
      tick();
      mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = data;
      tick();
      mem_rsp_valid = 0; mem_rdata = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 0;
      ifu_req_valid = 1; lsu_req_valid = 1; mem_rsp_valid = 1; mem_rdata = 32'hFFFF_FFFF;
      tick(); tick();
      #1;
      checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b want 00", {ifu_req_ready, lsu_req_ready}); end
      checks++; if ({mem_req_valid, mem_rsp_ready} !== 2'b00) begin errors++; $display("FAIL reset_mem_hs: got %b want 00", {mem_req_valid, mem_rsp_ready}); end
      checks++; if ({ifu_rsp_valid, lsu_rsp_valid} !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b want 00", {ifu_rsp_valid, lsu_rsp_valid}); end
      checks++; if ({ifu_rdata, lsu_rdata, mem_addr} !== 96'h0) begin errors++; $display("FAIL reset_data: got %h want 0", {ifu_rdata, lsu_rdata, mem_addr}); end
      tick();
      idle_inputs();
      rst = 1;
      #1;
      checks++; if (mem_rsp_ready !== 1'b1) begin errors++; $display("FAIL reset_idle_rsp_ready: got %b want 1", mem_rsp_ready); end
      tick();
   endtask

   task automatic test_tie_rr();
      ifu_req_valid = 1; ifu_addr = 32'h8000_0010;
      lsu_req_valid = 1; lsu_addr = 32'h8000_2000;
      #1;
      checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin errors++; $display("FAIL tie1_grant: got ifu/lsu %b want 01", {ifu_req_ready, lsu_req_ready}); end
      tick();
      lsu_req_valid = 0;
      #1;
      checks++; if (mem_addr !== 32'h8000_2000 || mem_req_valid !== 1'b1 || ifu_req_ready !== 1'b0) begin errors++; $display("FAIL tie1_mem_req: got addr %h valid %b ifu_ready %b want 80002000 1 0", mem_addr, mem_req_valid, ifu_req_ready); end
      mem_req_ready = 1;
      tick();
      mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'h1111_1111;
      #1;
      checks++; if ({lsu_rsp_valid, ifu_rsp_valid, ifu_req_ready} !== 3'b100 || lsu_rdata !== 32'h1111_1111) begin errors++; $display("FAIL tie1_rsp: got lsu_v/ifu_v/ifu_rdy %b rdata %h want 100 11111111", {lsu_rsp_valid, ifu_rsp_valid, ifu_req_ready}, lsu_rdata); end
      tick();
      mem_rsp_valid = 0; mem_rdata = '0;
      #1;
      checks++; if (ifu_req_ready !== 1'b1) begin errors++; $display("FAIL tie1_ifu_next: got %b want 1", ifu_req_ready); end
      tick();
      ifu_req_valid = 0;
      #1;
      checks++; if (mem_addr !== 32'h8000_0010) begin errors++; $display("FAIL tie1_ifu_addr: got %h want 80000010", mem_addr); end
      finish_txn(32'h2222_2222);
      // last_grant is IFU now: LSU wins the next tie, then IFU the one after.
      ifu_req_valid = 1; lsu_req_valid = 1;
      #1;
      checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin errors++; $display("FAIL tie2_grant: got ifu/lsu %b want 01", {ifu_req_ready, lsu_req_ready}); end
      tick();
      lsu_req_valid = 0;
      finish_txn(32'h3333_3333);
      lsu_req_valid = 1;
      #1;
      checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin errors++; $display("FAIL tie3_grant: got ifu/lsu %b want 10", {ifu_req_ready, lsu_req_ready}); end
      tick();
      ifu_req_valid = 0; lsu_req_valid = 0;
      finish_txn(32'h4444_4444);
   endtask

   task automatic test_single_ifu();
      ifu_req_valid = 1; ifu_addr = 32'h8000_0000; mem_req_ready = 1;
      #1;
      checks++; if ({ifu_req_ready, lsu_req_ready, mem_req_valid} !== 3'b100) begin errors++; $display("FAIL ifu_T: got %b want 100", {ifu_req_ready, lsu_req_ready, mem_req_valid}); end
      tick();
      ifu_req_valid = 0;
      #1;
      checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_0000 || {mem_wen, mem_wmask} !== 5'b0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL ifu_T1: got valid %b addr %h wen %b mask %b want 1 80000000 0 0000", mem_req_valid, mem_addr, mem_wen, mem_wmask); end
      tick();
      mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'h0000_0413;
      #1;
      checks++; if ({ifu_rsp_valid, ifu_rsp_err, lsu_rsp_valid} !== 3'b100 || ifu_rdata !== 32'h0000_0413) begin errors++; $display("FAIL ifu_T2: got v/err/lsu_v %b rdata %h want 100 00000413", {ifu_rsp_valid, ifu_rsp_err, lsu_rsp_valid}, ifu_rdata); end
      tick();
      mem_rsp_valid = 0; mem_rdata = '0;
      #1;
      checks++; if ({mem_rsp_ready, ifu_rsp_valid, mem_req_valid} !== 3'b100) begin errors++; $display("FAIL ifu_T3_idle: got %b want 100", {mem_rsp_ready, ifu_rsp_valid, mem_req_valid}); end
   endtask

   task automatic test_store_stall();
      lsu_req_valid = 1; lsu_addr = 32'h8000_1000; lsu_wen = 1;
      lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011;
      #1;
      checks++; if (lsu_req_ready !== 1'b1) begin errors++; $display("FAIL store_grant: got %b want 1", lsu_req_ready); end
      tick();
      lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++; if ({mem_req_valid, lsu_rsp_valid, mem_addr, mem_wen, mem_wdata, mem_wmask} !== {1'b1, 1'b0, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'b0011}) begin errors++; $display("FAIL store_stall_%0d: got v %b addr %h wen %b wdata %h mask %b want 1 80001000 1 deadbeef 0011", i, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask); end
         tick();
      end
      mem_req_ready = 1;
      #1;
      checks++; if (mem_req_valid !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_hs: got %b %h want 1 deadbeef", mem_req_valid, mem_wdata); end
      tick();
      mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'hCAFE_F00D;
      #1;
      checks++; if (lsu_rsp_valid !== 1'b1 || lsu_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL store_rsp: got %b %h want 1 cafef00d", lsu_rsp_valid, lsu_rdata); end
      tick();
      mem_rsp_valid = 0; mem_rdata = '0;
   endtask

   task automatic test_rsp_backpressure();
      ifu_req_valid = 1; ifu_addr = 32'h8000_0040;
      tick();
      ifu_req_valid = 0; mem_req_ready = 1;
      tick();
      mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'h0000_0055; ifu_rsp_ready = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if ({mem_rsp_ready, ifu_rsp_valid} !== 2'b01) begin errors++; $display("FAIL bp_hold_%0d: got mem_rdy/ifu_v %b want 01", i, {mem_rsp_ready, ifu_rsp_valid}); end
         tick();
      end
      ifu_rsp_ready = 1;
      #1;
      checks++; if ({mem_rsp_ready, ifu_rsp_valid} !== 2'b11 || ifu_rdata !== 32'h0000_0055) begin errors++; $display("FAIL bp_done: got %b %h want 11 00000055", {mem_rsp_ready, ifu_rsp_valid}, ifu_rdata); end
      tick();
      mem_rsp_valid = 0; mem_rdata = '0;
      #1;
      checks++; if ({mem_rsp_ready, mem_req_valid, ifu_rsp_valid} !== 3'b100) begin errors++; $display("FAIL bp_idle: got %b want 100", {mem_rsp_ready, mem_req_valid, ifu_rsp_valid}); end
   endtask

   task automatic test_timeout();
      lsu_req_valid = 1; lsu_addr = 32'h8000_3000;
      tick();
      lsu_req_valid = 0; mem_req_ready = 1;
      tick();
      mem_req_ready = 0; mem_rdata = 32'hFFFF_FFFF;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++; if (lsu_rsp_valid !== 1'b0) begin errors++; $display("FAIL to_wait_%0d: got %b want 0", i, lsu_rsp_valid); end
         tick();
      end
      lsu_rsp_ready = 0;
      #1;
      checks++; if ({lsu_rsp_valid, lsu_rsp_err, mem_rsp_ready, ifu_rsp_valid} !== 4'b1100 || lsu_rdata !== 32'h0) begin errors++; $display("FAIL to_err: got v/err/mrdy/ifu_v %b rdata %h want 1100 00000000", {lsu_rsp_valid, lsu_rsp_err, mem_rsp_ready, ifu_rsp_valid}, lsu_rdata); end
      tick();
      lsu_rsp_ready = 1;
      #1;
      checks++; if ({lsu_rsp_valid, lsu_rsp_err} !== 2'b11) begin errors++; $display("FAIL to_err_hold: got %b want 11", {lsu_rsp_valid, lsu_rsp_err}); end
      tick();
      mem_rsp_valid = 1; mem_rdata = 32'h1234_5678;
      #1;
      checks++; if ({mem_rsp_ready, lsu_rsp_valid, ifu_rsp_valid} !== 3'b100) begin errors++; $display("FAIL to_stray: got mrdy/lsu_v/ifu_v %b want 100", {mem_rsp_ready, lsu_rsp_valid, ifu_rsp_valid}); end
      tick();
      mem_rsp_valid = 0; mem_rdata = '0;
   endtask

   task automatic test_reset_mid();
      ifu_req_valid = 1; ifu_addr = 32'h8000_0080;
      tick();
      ifu_req_valid = 0; mem_req_ready = 1;
      tick();
      mem_req_ready = 0;
      rst = 0;
      tick();
      #1;
      checks++; if ({ifu_req_ready, lsu_req_ready, mem_req_valid, mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid} !== 6'b0) begin errors++; $display("FAIL rmid_outputs: got %b want 000000", {ifu_req_ready, lsu_req_ready, mem_req_valid, mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid}); end
      tick();
      rst = 1;
      ifu_req_valid = 1; lsu_req_valid = 1; mem_rsp_valid = 1; mem_rdata = 32'hABCD_0000;
      #1;
      checks++; if ({ifu_req_ready, lsu_req_ready, ifu_rsp_valid, mem_rsp_ready} !== 4'b0101) begin errors++; $display("FAIL rmid_after: got ifu_rdy/lsu_rdy/ifu_v/mrdy %b want 0101", {ifu_req_ready, lsu_req_ready, ifu_rsp_valid, mem_rsp_ready}); end
      tick();
      ifu_req_valid = 0; lsu_req_valid = 0; mem_rsp_valid = 0; mem_rdata = '0;
      finish_txn(32'h0);
   endtask

   initial begin
      rst = 0;
      test_reset();
      test_tie_rr();
      test_single_ifu();
      test_store_stall();
      test_rsp_backpressure();
      test_timeout();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
